// File: rtl/spi_flash_writer.sv
// SPI flash page programmer: word FIFO -> WREN, Page Program, RDSR poll (SPI mode 0).
// Optional status-poll timeout enabled by defining SPI_WRITER_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_flash_writer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_fifo_wr,
  input  logic [31:0] i_fifo_din,
  output logic        o_fifo_full,
  output logic [6:0]  o_fifo_cnt,
  input  logic        i_start,
  input  logic [23:0] i_addr,
  input  logic [6:0]  i_len_words,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        SPI_CSS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP1, S_PP, S_DATA, S_GAP2, S_POLL, S_DONE
  } state_t;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [6:0]    r_cnt;
  logic          w_full, w_empty, w_push, w_pop;
  logic [31:0]   w_rdata;

  assign w_full   = (r_cnt == 7'(FIFO_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_push   = i_fifo_wr && !w_full;
  assign w_rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_fifo_din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 7'd1;
        2'b01:   r_cnt <= r_cnt - 7'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  state_t      r_state;
  logic        r_css, r_sck, r_busy, r_done, r_error;
  logic [7:0]  r_div;
  logic [2:0]  r_bit;
  logic [7:0]  r_tx;
  logic        r_rx_bit;
  logic [23:0] r_word;
  logic [1:0]  r_bidx;
  logic [1:0]  r_bcnt;
  logic [6:0]  r_words_left;
  logic [23:0] r_addr;
  logic        r_need_word;
  logic        r_poll_cmd;
  logic [8:0]  r_gap;
`ifdef SPI_WRITER_TIMEOUT_EN
  logic [19:0] r_to_cnt;
`endif

  logic       w_shift, w_half, w_byte_end;
  logic [9:0] w_span;

  always_comb begin
    w_shift    = (r_state == S_WREN) || (r_state == S_PP) || (r_state == S_POLL) ||
                 ((r_state == S_DATA) && !r_need_word);
    w_half     = w_shift && (r_div == 8'(CLK_DIV - 1));
    w_byte_end = w_half && r_sck && (r_bit == 3'd7);
    w_span     = {2'b00, i_addr[7:0]} + {1'b0, i_len_words, 2'b00};
    // Pop exactly when a word's first bit is placed on MOSI (or when a stalled DATA phase resumes).
    w_pop = 1'b0;
    if (!w_empty) begin
      if ((r_state == S_DATA) && r_need_word)
        w_pop = 1'b1;
      else if (w_byte_end && (((r_state == S_PP) && (r_bcnt == 2'd3)) ||
               ((r_state == S_DATA) && (r_bidx == 2'd3) && (r_words_left != 7'd1))))
        w_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_css        <= 1'b1;
      r_sck        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_div        <= '0;
      r_bit        <= '0;
      r_tx         <= '0;
      r_rx_bit     <= 1'b0;
      r_word       <= '0;
      r_bidx       <= '0;
      r_bcnt       <= '0;
      r_words_left <= '0;
      r_addr       <= '0;
      r_need_word  <= 1'b0;
      r_poll_cmd   <= 1'b0;
      r_gap        <= '0;
`ifdef SPI_WRITER_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (w_shift) begin
        if (w_half) begin
          r_div <= '0;
          if (!r_sck) begin
            r_sck    <= 1'b1;
            r_rx_bit <= SPI_MISO;
          end else begin
            r_sck <= 1'b0;
            if (r_bit != 3'd7) begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= {r_tx[6:0], 1'b0};
            end else begin
              r_bit <= '0;
            end
          end
        end else begin
          r_div <= r_div + 8'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_span > 10'd256) begin
              r_error <= 1'b1;
            end else if (i_len_words == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy       <= 1'b1;
              r_css        <= 1'b0;
              r_addr       <= i_addr;
              r_words_left <= i_len_words;
              r_tx         <= 8'h06;
              r_state      <= S_WREN;
            end
          end
        end
        S_WREN: begin
          if (w_byte_end) begin
            r_css   <= 1'b1;
            r_tx    <= '0;
            r_gap   <= '0;
            r_state <= S_GAP1;
          end
        end
        S_GAP1: begin
          if (r_gap == 9'(2 * CLK_DIV - 1)) begin
            r_css   <= 1'b0;
            r_tx    <= 8'h02;
            r_bcnt  <= '0;
            r_state <= S_PP;
          end else begin
            r_gap <= r_gap + 9'd1;
          end
        end
        S_PP: begin
          if (w_byte_end) begin
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_tx <= r_addr[23:16];
              2'd1: r_tx <= r_addr[15:8];
              2'd2: r_tx <= r_addr[7:0];
              default: begin
                r_state <= S_DATA;
                r_bidx  <= '0;
                if (w_pop) begin
                  r_tx        <= w_rdata[7:0];
                  r_word      <= w_rdata[31:8];
                  r_need_word <= 1'b0;
                end else begin
                  r_need_word <= 1'b1;
                end
              end
            endcase
          end
        end
        S_DATA: begin
          if (r_need_word) begin
            if (w_pop) begin
              r_tx        <= w_rdata[7:0];
              r_word      <= w_rdata[31:8];
              r_bidx      <= '0;
              r_need_word <= 1'b0;
            end
          end else if (w_byte_end) begin
            if (r_bidx != 2'd3) begin
              r_bidx <= r_bidx + 2'd1;
              r_tx   <= r_word[7:0];
              r_word <= {8'h00, r_word[23:8]};
            end else begin
              r_words_left <= r_words_left - 7'd1;
              r_bidx       <= '0;
              if (r_words_left == 7'd1) begin
                r_css   <= 1'b1;
                r_tx    <= '0;
                r_gap   <= '0;
                r_state <= S_GAP2;
              end else if (w_pop) begin
                r_tx   <= w_rdata[7:0];
                r_word <= w_rdata[31:8];
              end else begin
                r_need_word <= 1'b1;
              end
            end
          end
        end
        S_GAP2: begin
          if (r_gap == 9'(2 * CLK_DIV - 1)) begin
            r_css      <= 1'b0;
            r_tx       <= 8'h05;
            r_poll_cmd <= 1'b1;
`ifdef SPI_WRITER_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
            r_state    <= S_POLL;
          end else begin
            r_gap <= r_gap + 9'd1;
          end
        end
        S_POLL: begin
          // WIP is the last bit of each status byte, so only the final sample is kept.
          if (w_byte_end) begin
            r_tx <= '0;
            if (r_poll_cmd) begin
              r_poll_cmd <= 1'b0;
            end else if (!r_rx_bit) begin
              r_css   <= 1'b1;
              r_state <= S_DONE;
            end else begin
`ifdef SPI_WRITER_TIMEOUT_EN
              if (r_to_cnt == 20'hFFFFE) begin
                r_css   <= 1'b1;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_to_cnt <= r_to_cnt + 20'd1;
              end
`endif
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_fifo_full = w_full;
  assign o_fifo_cnt  = r_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign SPI_CSS     = r_css;
  assign SPI_CLK     = r_sck;
  assign SPI_MOSI    = r_tx[7];

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: SPI slave monitor + flash status model, frames compared
// against a command/byte-list reference built from addr, length and pushed words.
`timescale 1ns/1ps
module tb_spi_flash_writer;
  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_fifo_wr;
  logic [31:0] i_fifo_din;
  logic        o_fifo_full;
  logic [6:0]  o_fifo_cnt;
  logic        i_start;
  logic [23:0] i_addr;
  logic [6:0]  i_len_words;
  logic        o_busy, o_done, o_error;
  logic        SPI_CSS, SPI_CLK, SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  spi_flash_writer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .i_fifo_wr(i_fifo_wr), .i_fifo_din(i_fifo_din),
    .o_fifo_full(o_fifo_full), .o_fifo_cnt(o_fifo_cnt),
    .i_start(i_start), .i_addr(i_addr), .i_len_words(i_len_words),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .SPI_CSS(SPI_CSS), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave-side monitor and flash status model
  logic [7:0]  mon_bytes[$];
  int          frame_len[$];
  int          cur_len = 0;
  int          bitn = 0;
  logic [7:0]  sh = '0;
  logic [7:0]  cur_cmd = '0;
  logic [7:0]  sb;
  int          sck_rises = 0;
  int          busy_n = 0;
  int          cyc = 0;
  int          hi_cyc = 0;
  int          min_gap = 1000000;
  int          done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [31:0] g_words[$];

  function automatic logic [7:0] stat_byte(input int k);
    return (k < busy_n) ? 8'h03 : 8'h02;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_error) err_cnt++;
    if (o_done && o_error) both_cnt++;
  end

  always @(negedge SPI_CSS) begin
    bitn = 0; cur_len = 0; cur_cmd = '0; SPI_MISO = 1'b0;
    if (cyc - hi_cyc < min_gap) min_gap = cyc - hi_cyc;
  end

  always @(posedge SPI_CSS) begin
    frame_len.push_back(cur_len);
    hi_cyc = cyc;
  end

  always @(posedge SPI_CLK) begin
    sck_rises++;
    if (!SPI_CSS) begin
      sh = {sh[6:0], SPI_MOSI};
      bitn++;
      if (bitn % 8 == 0) begin
        mon_bytes.push_back(sh);
        if (cur_len == 0) cur_cmd = sh;
        cur_len++;
      end
    end
  end

  always @(negedge SPI_CLK) begin
    if (!SPI_CSS && cur_cmd == 8'h05 && bitn >= 8) begin
      sb = stat_byte(bitn / 8 - 1);
      SPI_MISO = sb[7 - bitn % 8];
    end
  end

  task automatic push_word(input logic [31:0] w);
    @(negedge clk); i_fifo_wr = 1'b1; i_fifo_din = w;
    @(negedge clk); i_fifo_wr = 1'b0;
  endtask

  // mode 0: all words pushed before start; 1: some pushed during transfer;
  // 2: none before start, stall checked; 3: words already in g_words and FIFO
  task automatic run_txn(input logic [23:0] addr, input int len, input int bn, input int mode);
    int d0, e0, t, npre, r0, nexp;
    logic [7:0] exp_b[$];
    logic [31:0] w;
    busy_n = bn;
    if (mode != 3) begin
      g_words.delete();
      for (int i = 0; i < len; i++) g_words.push_back($urandom);
    end
    npre = (mode == 0 || mode == 3) ? len : (mode == 1) ? $urandom_range(0, len) : 0;
    if (mode != 3) for (int i = 0; i < npre; i++) push_word(g_words[i]);
    mon_bytes.delete(); frame_len.delete(); min_gap = 1000000;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk); i_start = 1'b1; i_addr = addr; i_len_words = 7'(len);
    @(negedge clk); i_start = 1'b0; i_addr = 24'($urandom); i_len_words = 7'($urandom);
    check("accept_busy", o_busy, 1);
    check("accept_css", SPI_CSS, 0);
    repeat (10) @(negedge clk);
    i_start = 1'b1; i_addr = 24'h0000FF; i_len_words = 7'd64;
    @(negedge clk); i_start = 1'b0;
    if (mode == 2) begin
      repeat (250) @(negedge clk);
      r0 = sck_rises;
      repeat (20) @(negedge clk);
      check("stall_sck", sck_rises - r0, 0);
      check("stall_css", SPI_CSS, 0);
      check("stall_bytes", cur_len, 4);
    end
    for (int i = npre; i < len; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      push_word(g_words[i]);
    end
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
    check("done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("no_error", err_cnt - e0, 0);
    check("end_busy", o_busy, 0);
    check("end_css", SPI_CSS, 1);
    check("end_fifo_cnt", o_fifo_cnt, 0);
    exp_b.push_back(8'h06);
    exp_b.push_back(8'h02);
    exp_b.push_back(addr[23:16]); exp_b.push_back(addr[15:8]); exp_b.push_back(addr[7:0]);
    for (int i = 0; i < len; i++) begin
      w = g_words[i];
      for (int b = 0; b < 4; b++) exp_b.push_back(8'((w >> (8 * b)) & 32'hFF));
    end
    exp_b.push_back(8'h05);
    check("frame_count", frame_len.size(), 3);
    if (frame_len.size() == 3) begin
      check("frame_wren_len", frame_len[0], 1);
      check("frame_pp_len", frame_len[1], 4 + 4 * len);
      check("frame_poll_len", frame_len[2], 2 + bn);
    end
    nexp = exp_b.size();
    for (int i = 0; i < nexp; i++)
      check($sformatf("mosi_byte%0d", i), (i < mon_bytes.size()) ? mon_bytes[i] : 8'hxx, exp_b[i]);
    check("css_gap", min_gap >= 2 * CLK_DIV, 1);
  endtask

  initial begin
    int d0, e0, r0, t, len;
    logic [31:0] w;
    logic [23:0] a;
    resetn = 1'b0; i_fifo_wr = 1'b0; i_fifo_din = '0; i_start = 1'b0;
    i_addr = '0; i_len_words = '0;
    repeat (3) @(negedge clk);
    check("rst_css", SPI_CSS, 1);
    check("rst_sck", SPI_CLK, 0);
    check("rst_mosi", SPI_MOSI, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_full", o_fifo_full, 0);
    check("rst_cnt", o_fifo_cnt, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Page-boundary reject with two words waiting in the FIFO
    g_words.delete();
    g_words.push_back(32'h44332211); g_words.push_back(32'h88776655);
    push_word(g_words[0]); push_word(g_words[1]);
    mon_bytes.delete(); frame_len.delete();
    e0 = err_cnt; d0 = done_cnt; r0 = sck_rises;
    @(negedge clk); i_start = 1'b1; i_addr = 24'h0000F8; i_len_words = 7'd3;
    @(negedge clk); i_start = 1'b0;
    check("perr_pulse", o_error, 1);
    check("perr_nodone", o_done, 0);
    check("perr_busy", o_busy, 0);
    repeat (20) @(negedge clk);
    check("perr_once", err_cnt - e0, 1);
    check("perr_done_none", done_cnt - d0, 0);
    check("perr_frames", frame_len.size(), 0);
    check("perr_sck", sck_rises - r0, 0);
    check("perr_cnt", o_fifo_cnt, 2);

    run_txn(24'h012340, 2, 1, 3);

    // Zero-length start
    d0 = done_cnt; r0 = sck_rises; frame_len.delete();
    @(negedge clk); i_start = 1'b1; i_addr = 24'($urandom); i_len_words = 7'd0;
    @(negedge clk); i_start = 1'b0;
    check("len0_done", o_done, 1);
    check("len0_busy", o_busy, 0);
    @(negedge clk);
    check("len0_done_low", o_done, 0);
    check("len0_once", done_cnt - d0, 1);
    check("len0_sck", sck_rises - r0, 0);
    check("len0_frames", frame_len.size(), 0);

    run_txn({8'($urandom), 8'($urandom), 8'($urandom_range(0, 248))}, 2, 2, 2);

    // Overflow: 17 pushes into a 16-deep FIFO, then program the 16 kept words
    g_words.delete();
    for (int i = 0; i < 17; i++) begin
      w = $urandom;
      if (i < 16) g_words.push_back(w);
      push_word(w);
      if (i == 14) check("not_full_at15", o_fifo_full, 0);
      if (i == 15) begin
        check("full_at16", o_fifo_full, 1);
        check("cnt_at16", o_fifo_cnt, 16);
      end
    end
    check("cnt_after17", o_fifo_cnt, 16);
    check("full_after17", o_fifo_full, 1);
    run_txn(24'h200000, 16, 3, 3);

    // Reset in the middle of the data phase
    g_words.delete();
    for (int i = 0; i < 4; i++) begin w = $urandom; g_words.push_back(w); push_word(w); end
    busy_n = 0;
    @(negedge clk); i_start = 1'b1; i_addr = 24'h100010; i_len_words = 7'd4;
    @(negedge clk); i_start = 1'b0;
    t = 0;
    while (!(cur_cmd == 8'h02 && cur_len >= 6) && t < 5000) begin @(negedge clk); t++; end
    check("rst_reached_data", cur_cmd == 8'h02 && cur_len >= 6, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_css", SPI_CSS, 1);
    check("arst_sck", SPI_CLK, 0);
    check("arst_mosi", SPI_MOSI, 0);
    check("arst_busy", o_busy, 0);
    check("arst_cnt", o_fifo_cnt, 0);
    check("arst_full", o_fifo_full, 0);
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(24'h3000A0, 3, 1, 0);

    // Randomised transactions, including one that ends exactly on the page boundary
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(1, 8);
      a = {8'($urandom), 8'($urandom), 8'($urandom_range(0, 256 - 4 * len))};
      if (n == 3) a[7:0] = 8'(256 - 4 * len);
      run_txn(a, len, $urandom_range(0, 3), (n % 2 == 0) ? 0 : 1);
    end

    check("done_error_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
